// File: rtl/ysyx_25040129_exu_ctrl.sv
// Execute-stage issue/handshake controller: one-slot buffer feeding the EXU,
// multi-cycle sequencing, load-use stall, branch redirect and forwarding tags.
module ysyx_25040129_exu_ctrl #(
    parameter int PAYLOAD_W = 160,
    parameter int REGS_DIG  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [REGS_DIG-1:0]  in_rd,
    input  logic                 in_reg_write,
    input  logic [2:0]           in_lsu_read,
    input  logic                 in_is_mc,
    input  logic [REGS_DIG-1:0]  in_rs1,
    input  logic [REGS_DIG-1:0]  in_rs2,
    input  logic                 in_rs1_used,
    input  logic                 in_rs2_used,
    output logic [PAYLOAD_W-1:0] ex_payload,
    output logic                 ex_valid,
    output logic                 mc_start,
    input  logic                 mc_done,
    input  logic                 br_taken,
    input  logic [31:0]          br_target,
    output logic                 redirect_valid,
    output logic [31:0]          redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 fwd_valid,
    output logic [REGS_DIG-1:0]  fwd_rd,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        MC_BUSY = 2'd1,
        READY   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [REGS_DIG-1:0]   slot_rd;
    logic                  slot_reg_write;
    logic [2:0]            slot_lsu_read;
    logic                  slot_is_mc;
    logic                  mc_start_q;
    logic                  hazard;
    logic                  fire;
    logic                  out_fire;

    assign ex_valid = (state_q != EMPTY);
    assign mc_start = mc_start_q;

    // Only a load still sitting in the slot can create a load-use bubble.
    assign hazard = ex_valid && (slot_lsu_read != 3'd0) && slot_reg_write
                 && (slot_rd != '0)
                 && ((in_rs1_used && (in_rs1 == slot_rd))
                  || (in_rs2_used && (in_rs2 == slot_rd)));

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            EMPTY:   in_ready = !hazard;
            MC_BUSY: in_ready = 1'b0;
            READY: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !br_taken && !hazard;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign fire     = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign redirect_valid = out_fire && br_taken;
    assign redirect_pc    = redirect_valid ? br_target : 32'd0;

    assign fwd_valid = (state_q == READY) && (slot_lsu_read == 3'd0)
                    && slot_reg_write && (slot_rd != '0);
    assign fwd_rd    = fwd_valid ? slot_rd : '0;

    // A fire always implies the slot is free or draining this cycle.
    always_comb begin
        state_d = state_q;
        if (fire) begin
            state_d = in_is_mc ? MC_BUSY : READY;
        end else if (state_q == MC_BUSY && mc_done) begin
            state_d = READY;
        end else if (state_q == READY && out_fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EMPTY;
            mc_start_q     <= 1'b0;
            ex_payload     <= '0;
            slot_rd        <= '0;
            slot_reg_write <= 1'b0;
            slot_lsu_read  <= 3'd0;
            slot_is_mc     <= 1'b0;
            stall_cnt      <= 32'd0;
        end else begin
            state_q    <= state_d;
            mc_start_q <= fire && in_is_mc;
            if (fire) begin
                ex_payload     <= in_payload;
                slot_rd        <= in_rd;
                slot_reg_write <= in_reg_write;
                slot_lsu_read  <= in_lsu_read;
                slot_is_mc     <= in_is_mc;
            end
            if (in_valid && !in_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25040129_exu_ctrl.sv
// Directed bench for the execute-stage controller.
module tb_ysyx_25040129_exu_ctrl;

    localparam int PW = 160;
    localparam int RD = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic [RD-1:0] in_rd;
    logic          in_reg_write;
    logic [2:0]    in_lsu_read;
    logic          in_is_mc;
    logic [RD-1:0] in_rs1;
    logic [RD-1:0] in_rs2;
    logic          in_rs1_used;
    logic          in_rs2_used;
    logic [PW-1:0] ex_payload;
    logic          ex_valid;
    logic          mc_start;
    logic          mc_done;
    logic          br_taken;
    logic [31:0]   br_target;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic          fwd_valid;
    logic [RD-1:0] fwd_rd;
    logic [31:0]   stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_25040129_exu_ctrl #(.PAYLOAD_W(PW), .REGS_DIG(RD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .in_lsu_read(in_lsu_read),
        .in_is_mc(in_is_mc), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
        .ex_payload(ex_payload), .ex_valid(ex_valid), .mc_start(mc_start),
        .mc_done(mc_done), .br_taken(br_taken), .br_target(br_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_payload = '0; in_rd = '0; in_reg_write = 0;
        in_lsu_read = 3'd0; in_is_mc = 0; in_rs1 = '0; in_rs2 = '0;
        in_rs1_used = 0; in_rs2_used = 0; mc_done = 0; br_taken = 0;
        br_target = 32'd0; out_ready = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic offer(input logic [PW-1:0] p, input logic [RD-1:0] rd,
                         input logic [2:0] ld, input logic mc);
        in_valid = 1; in_payload = p; in_rd = rd; in_reg_write = 1;
        in_lsu_read = ld; in_is_mc = mc;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
        checks++; if (mc_start !== 1'b0) begin failures++; $display("FAIL reset_mc_start got=%0h exp=0", mc_start); end
        checks++; if (ex_payload !== '0) begin failures++; $display("FAIL reset_payload got=%0h exp=0", ex_payload); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
        checks++; if (fwd_valid !== 1'b0 || fwd_rd !== '0) begin failures++; $display("FAIL reset_fwd got=%0h/%0h exp=0/0", fwd_valid, fwd_rd); end
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin failures++; $display("FAIL reset_redirect got=%0h/%0h exp=0/0", redirect_valid, redirect_pc); end
    endtask

    task automatic test_back_to_back();
        logic [RD-1:0] exp_rd;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            offer(PW'(32'hA0 + i), RD'(i), 3'd0, 1'b0);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready%0d got=%0h exp=1", i, in_ready); end
            tick();
            exp_rd = RD'(i);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_out_valid%0d got=%0h exp=1", i, out_valid); end
            checks++; if (fwd_rd !== exp_rd || fwd_valid !== 1'b1) begin failures++; $display("FAIL b2b_fwd_rd%0d got=%0d exp=%0d", i, fwd_rd, exp_rd); end
            checks++; if (ex_payload !== PW'(32'hA0 + i)) begin failures++; $display("FAIL b2b_payload%0d got=%0h exp=%0h", i, ex_payload, 32'hA0 + i); end
        end
        in_valid = 0;
        tick();
        checks++; if (ex_valid !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h/%0h exp=0/0", ex_valid, out_valid); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_multicycle();
        do_reset();
        offer(PW'(32'hC0DE), 5'd4, 3'd0, 1'b1);
        tick();
        offer(PW'(32'hBEEF), 5'd6, 3'd0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            mc_done = (c == 5);
            #1;
            checks++; if (mc_start !== (c == 1)) begin failures++; $display("FAIL mc_start_c%0d got=%0h exp=%0h", c, mc_start, (c == 1)); end
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL mc_busy_c%0d got=%0h/%0h exp=0/0", c, out_valid, in_ready); end
            tick();
        end
        mc_done = 0;
        #1;
        checks++; if (out_valid !== 1'b1 || mc_start !== 1'b0) begin failures++; $display("FAIL mc_done_out got=%0h/%0h exp=1/0", out_valid, mc_start); end
        checks++; if (stall_cnt !== 32'd5) begin failures++; $display("FAIL mc_stall got=%0d exp=5", stall_cnt); end
        checks++; if (fwd_rd !== 5'd4 || ex_payload !== PW'(32'hC0DE)) begin failures++; $display("FAIL mc_result got=%0d/%0h exp=4/c0de", fwd_rd, ex_payload); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mc_next_ready got=%0h exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (fwd_rd !== 5'd6 || ex_payload !== PW'(32'hBEEF) || mc_start !== 1'b0) begin failures++; $display("FAIL mc_follow got=%0d/%0h/%0h exp=6/beef/0", fwd_rd, ex_payload, mc_start); end
        mc_done = 1;
        tick();
        mc_done = 0;
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL mc_stray_done got=%0h exp=0", ex_valid); end
    endtask

    task automatic test_load_use();
        do_reset();
        out_ready = 0;
        offer(PW'(32'h10AD), 5'd5, 3'd2, 1'b0);
        tick();
        checks++; if (fwd_valid !== 1'b0) begin failures++; $display("FAIL lu_no_fwd got=%0h exp=0", fwd_valid); end
        offer(PW'(32'h0DD), 5'd7, 3'd0, 1'b0);
        in_rs1 = 5'd5; in_rs1_used = 1;
        for (int c = 1; c <= 3; c++) begin
            out_ready = (c == 3);
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall_c%0d got=%0h exp=0", c, in_ready); end
            tick();
        end
        checks++; if (in_ready !== 1'b1 || ex_valid !== 1'b0) begin failures++; $display("FAIL lu_release got=%0h/%0h exp=1/0", in_ready, ex_valid); end
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=3", stall_cnt); end
        tick();
        in_valid = 0; in_rs1_used = 0;
        checks++; if (ex_payload !== PW'(32'h0DD) || fwd_rd !== 5'd7) begin failures++; $display("FAIL lu_accept got=%0h/%0d exp=dd/7", ex_payload, fwd_rd); end

        do_reset();
        offer(PW'(32'h10AE), 5'd5, 3'd1, 1'b0);
        tick();
        offer(PW'(32'h0EE), 5'd8, 3'd0, 1'b0);
        in_rs2 = 5'd5; in_rs2_used = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_rs2_hazard got=%0h exp=0", in_ready); end
        in_rs2_used = 0; in_rs1 = 5'd5; in_rs1_used = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_unused got=%0h exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (ex_payload !== PW'(32'h0EE) || stall_cnt !== 32'd0) begin failures++; $display("FAIL lu_nostall got=%0h/%0d exp=ee/0", ex_payload, stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        offer(PW'(32'hB0), 5'd0, 3'd0, 1'b0);
        tick();
        offer(PW'(32'hBAD), 5'd9, 3'd0, 1'b0);
        br_taken = 1; br_target = 32'h8000_0100; out_ready = 0;
        #1;
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin failures++; $display("FAIL br_held got=%0h/%0h exp=0/0", redirect_valid, redirect_pc); end
        tick();
        out_ready = 1;
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0100) begin failures++; $display("FAIL br_redirect got=%0h/%0h exp=1/80000100", redirect_valid, redirect_pc); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL br_block got=%0h exp=0", in_ready); end
        tick();
        in_valid = 0; br_taken = 0;
        checks++; if (ex_valid !== 1'b0 || redirect_valid !== 1'b0) begin failures++; $display("FAIL br_empty got=%0h/%0h exp=0/0", ex_valid, redirect_valid); end
        checks++; if (ex_payload !== PW'(32'hB0)) begin failures++; $display("FAIL br_wrongpath got=%0h exp=b0", ex_payload); end
        checks++; if (stall_cnt !== 32'd2) begin failures++; $display("FAIL br_stall got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(PW'(32'hCC), 5'd9, 3'd0, 1'b0);
        tick();
        offer(PW'(32'hDD), 5'd10, 3'd0, 1'b0);
        out_ready = 0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            checks++; if (ex_payload !== PW'(32'hCC) || in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_c%0d got=%0h/%0h/%0h exp=cc/0/1", c, ex_payload, in_ready, out_valid); end
            tick();
        end
        checks++; if (stall_cnt !== 32'd3) begin failures++; $display("FAIL bp_stall got=%0d exp=3", stall_cnt); end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0h exp=1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (ex_payload !== PW'(32'hDD) || fwd_rd !== 5'd10) begin failures++; $display("FAIL bp_next got=%0h/%0d exp=dd/10", ex_payload, fwd_rd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        offer(PW'(32'hEE), 5'd3, 3'd0, 1'b1);
        tick();
        tick();
        checks++; if (ex_valid !== 1'b1 || stall_cnt !== 32'd1) begin failures++; $display("FAIL ar_busy got=%0h/%0d exp=1/1", ex_valid, stall_cnt); end
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        checks++; if (ex_valid !== 1'b0 || ex_payload !== '0 || stall_cnt !== 32'd0 || mc_start !== 1'b0) begin failures++; $display("FAIL ar_async got=%0h/%0h/%0d/%0h exp=0/0/0/0", ex_valid, ex_payload, stall_cnt, mc_start); end
        tick();
        rst = 0;
        mc_done = 1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL ar_after got=%0h/%0h exp=1/0", in_ready, out_valid); end
        tick();
        mc_done = 0;
        tick();
        checks++; if (out_valid !== 1'b0 || ex_valid !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL ar_spurious_done got=%0h/%0h/%0h exp=0/0/0", out_valid, ex_valid, fwd_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_multicycle();
        test_load_use();
        test_branch();
        test_backpressure();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
